// File: rtl/celera_softstart_dacseq.sv
// Soft-start ramp sequencer for the 6-bit R2R DAC: wakes the DAC, steps the code
// one LSB per settle handshake toward the target, and ramps back to zero on disable.
`timescale 1ns/1ps
module celera_softstart_dacseq #(
    parameter int unsigned TIMEOUT_W = 5,
    parameter int unsigned TIMEOUT   = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [5:0] target,
    input  logic [7:0] step_div,
    input  logic       ok_dac,
    output logic [5:0] dac_code,
    output logic       strobe_dac,
    output logic       global_dac,
    output logic       ramp_busy,
    output logic       ramp_done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_HOLD,
        S_STEP,
        S_SETTLE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] BLANK    = TIMEOUT_W'(2);

    state_t               state_q, state_d;
    logic                 ok_s1_q, ok_s2_q;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [7:0]           dwell_q, dwell_d;
    logic [5:0]           code_q, code_d;
    logic                 strobe_q, strobe_d;
    logic                 gdac_q, gdac_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fault_q, fault_d;

    logic [5:0] tgt_e;
    logic [7:0] div_e;
    logic       dwell_exp;
    logic       tmo_exp;
    logic       blank_done;

    assign tgt_e      = en ? target : '0;
    assign div_e      = (step_div == '0) ? 8'd1 : step_div;
    assign dwell_exp  = (dwell_q >= (div_e - 8'd1));
    assign tmo_exp    = (tmo_q == TMO_LAST);
    // The timeout counter doubles as the SETTLE blanking timer.
    assign blank_done = (tmo_q >= BLANK);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        tmo_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (en) state_d = S_WAKE;
            end
            S_WAKE: begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
                if (!en) begin
                    state_d = S_IDLE;
                end else if (ok_s2_q) begin
                    state_d = S_HOLD;
                    dwell_d = '1;
                end else if (tmo_exp) begin
                    state_d = S_FAULT;
                end
            end
            S_HOLD: begin
                dwell_d = dwell_q + 8'd1;
                if (dwell_exp) begin
                    if (code_q == tgt_e) begin
                        state_d = en ? S_DONE : S_IDLE;
                    end else begin
                        state_d = S_STEP;
                        code_d  = (tgt_e > code_q) ? code_q + 6'd1 : code_q - 6'd1;
                    end
                end
            end
            S_STEP: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
                if (blank_done && ok_s2_q) begin
                    state_d = S_HOLD;
                    dwell_d = '0;
                end else if (tmo_exp) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE: begin
                if (!en || (tgt_e != code_q)) begin
                    state_d = S_HOLD;
                    dwell_d = '1;
                end
            end
            S_FAULT: begin
                if (!en) begin
                    state_d = S_IDLE;
                    code_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                code_d  = '0;
            end
        endcase

        strobe_d = (state_d == S_STEP);
        gdac_d   = (state_d != S_IDLE);
        busy_d   = (state_d == S_WAKE) || (state_d == S_STEP) ||
                   (state_d == S_SETTLE) || (state_d == S_HOLD);
        done_d   = (state_d == S_DONE);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ok_s1_q  <= 1'b0;
            ok_s2_q  <= 1'b0;
            tmo_q    <= '0;
            dwell_q  <= '0;
            code_q   <= '0;
            strobe_q <= 1'b0;
            gdac_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ok_s1_q  <= ok_dac;
            ok_s2_q  <= ok_s1_q;
            tmo_q    <= tmo_d;
            dwell_q  <= dwell_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            gdac_q   <= gdac_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
        end
    end

    assign dac_code   = code_q;
    assign strobe_dac = strobe_q;
    assign global_dac = gdac_q;
    assign ramp_busy  = busy_q;
    assign ramp_done  = done_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_celera_softstart_dacseq.sv
// Directed bench for celera_softstart_dacseq: per-cycle rule model plus literal timing checks.
`timescale 1ns/1ps
module tb_celera_softstart_dacseq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] target;
    logic [7:0] step_div;
    logic       ok_dac;
    logic [5:0] dac_code;
    logic       strobe_dac;
    logic       global_dac;
    logic       ramp_busy;
    logic       ramp_done;
    logic       fault;

    celera_softstart_dacseq #(
        .TIMEOUT_W(5),
        .TIMEOUT  (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .target    (target),
        .step_div  (step_div),
        .ok_dac    (ok_dac),
        .dac_code  (dac_code),
        .strobe_dac(strobe_dac),
        .global_dac(global_dac),
        .ramp_busy (ramp_busy),
        .ramp_done (ramp_done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int seen_tgt = 0;
    int m_code   = 0;
    int strobe_cyc[$];
    int strobe_code[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int step_toward(input int c, input int t);
        if (t > c) return c + 1;
        if (t < c) return c - 1;
        return c;
    endfunction

    // Effective target as seen by the DUT on each rising edge.
    always @(posedge clk) begin
        cyc++;
        seen_tgt = en ? int'(target) : 0;
    end

    always @(negedge clk) begin
        int prev;
        if (!rst_n) begin
            m_code = 0;
        end else begin
            chk("power_vs_state", int'(global_dac), int'(ramp_busy | ramp_done | fault));
            chk("state_exclusive", int'((int'(ramp_busy) + int'(ramp_done) + int'(fault)) <= 1), 1);
            if (!global_dac) begin
                chk("idle_code", int'(dac_code), 0);
                chk("idle_strobe", int'(strobe_dac), 0);
                m_code = 0;
            end else if (strobe_dac) begin
                prev = m_code;
                chk("strobe_needed", int'(prev != seen_tgt), 1);
                chk("strobe_in_fault", int'(fault), 0);
                m_code = step_toward(prev, seen_tgt);
                chk("strobe_code", int'(dac_code), m_code);
                strobe_cyc.push_back(cyc);
                strobe_code.push_back(int'(dac_code));
            end else begin
                chk("code_hold", int'(dac_code), m_code);
            end
            if (ramp_done) chk("done_at_target", int'(dac_code), seen_tgt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (strobe_cyc.size() >= n) break;
            @(negedge clk);
            #1;
        end
        chk(name, strobe_cyc.size(), n);
    endtask

    // sel: 0 = ramp_done, 1 = powered down, 2 = fault
    task automatic wait_state(input int sel, input int budget, input string name, output int at);
        logic hit;
        hit = 1'b0;
        at  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            hit = (sel == 0) ? ramp_done : (sel == 1) ? !global_dac : fault;
            if (hit) begin
                at = cyc;
                break;
            end
        end
        chk(name, int'(hit), 1);
    endtask

    int t0, n0, n1, n2, n3, n4, n5, n6, n7, s, r, at;

    initial begin
        rst_n = 1'b0; en = 1'b0; target = 6'd0; step_div = 8'd3; ok_dac = 1'b1;
        tick(3);
        chk("rst_code", int'(dac_code), 0);
        chk("rst_strobe", int'(strobe_dac), 0);
        chk("rst_global", int'(global_dac), 0);
        chk("rst_busy", int'(ramp_busy), 0);
        chk("rst_done", int'(ramp_done), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1'b1;
        tick(3);

        // Ramp up 0 -> 5 with ok_dac tied high, step_div = 3
        target = 6'd5; en = 1'b1; t0 = cyc; n0 = strobe_cyc.size();
        #1 chk("en_lat_pre", int'(global_dac), 0);
        tick(1);
        chk("en_lat", int'(global_dac), 1);
        chk("wake_busy", int'(ramp_busy), 1);
        wait_strobes(n0 + 5, 100, "up_strobes");
        chk("up_first_lat", strobe_cyc[n0] - t0, 3);
        for (int i = 0; i < 5; i++) chk("up_code", strobe_code[n0 + i], i + 1);
        for (int i = 1; i < 5; i++) chk("up_gap", strobe_cyc[n0 + i] - strobe_cyc[n0 + i - 1], 7);
        wait_state(0, 30, "up_done", at);
        chk("up_done_lat", at - strobe_cyc[n0 + 4], 7);
        chk("up_busy_low", int'(ramp_busy), 0);
        chk("up_final", int'(dac_code), 5);

        // Retarget down to 2 from DONE, then rewrite the same target
        tick(1);
        target = 6'd2; t0 = cyc; n1 = strobe_cyc.size();
        wait_strobes(n1 + 3, 100, "dn_strobes");
        chk("dn_first_lat", strobe_cyc[n1] - t0, 2);
        for (int i = 0; i < 3; i++) chk("dn_code", strobe_code[n1 + i], 4 - i);
        wait_state(0, 30, "dn_done", at);
        tick(2);
        target = 6'd2;
        tick(20);
        chk("same_tgt_no_strobe", strobe_cyc.size(), n1 + 3);
        chk("same_tgt_done", int'(ramp_done), 1);

        // en falls during SETTLE at code 3: settle completes, then ramp to 0
        tick(1);
        target = 6'd5; n2 = strobe_cyc.size();
        wait_strobes(n2 + 1, 30, "fall_first");
        chk("fall_code3", strobe_code[n2], 3);
        tick(1);
        en = 1'b0;
        wait_strobes(n2 + 4, 100, "fall_strobes");
        for (int i = 1; i < 4; i++) chk("fall_code", strobe_code[n2 + i], 3 - i);
        chk("fall_gap", strobe_cyc[n2 + 1] - strobe_cyc[n2], 7);
        wait_state(1, 30, "fall_idle", at);
        chk("fall_idle_lat", at - strobe_cyc[n2 + 3], 7);

        // en falls while in WAKE
        ok_dac = 1'b0;
        tick(4);
        n3 = strobe_cyc.size(); en = 1'b1; target = 6'd5;
        tick(1);
        chk("wake_abort_on", int'(global_dac), 1);
        en = 1'b0;
        tick(1);
        chk("wake_abort_off", int'(global_dac), 0);
        chk("wake_abort_busy", int'(ramp_busy), 0);
        tick(5);
        chk("wake_abort_nostrobe", strobe_cyc.size(), n3);

        // ok_dac lost after the first strobe: settle timeout
        ok_dac = 1'b1;
        tick(3);
        en = 1'b1; n4 = strobe_cyc.size();
        wait_strobes(n4 + 1, 30, "to_first");
        ok_dac = 1'b0;
        s = strobe_cyc[n4];
        chk("to_code", strobe_code[n4], 1);
        wait_state(2, 60, "to_fault", at);
        chk("to_lat", at - s, 25);
        tick(20);
        chk("to_nostrobe", strobe_cyc.size(), n4 + 1);
        chk("to_fault_hold", int'(fault), 1);
        chk("to_global", int'(global_dac), 1);
        chk("to_code_hold", int'(dac_code), 1);
        en = 1'b0;
        tick(1);
        chk("to_clr_code", int'(dac_code), 0);
        chk("to_clr_fault", int'(fault), 0);
        chk("to_clr_global", int'(global_dac), 0);
        chk("to_clr_busy", int'(ramp_busy), 0);
        chk("to_clr_done", int'(ramp_done), 0);

        // Asynchronous reset mid-ramp at code 4
        ok_dac = 1'b1;
        tick(4);
        en = 1'b1; n5 = strobe_cyc.size();
        wait_strobes(n5 + 4, 100, "ar_strobes");
        chk("ar_code4", strobe_code[n5 + 3], 4);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_code", int'(dac_code), 0);
        chk("ar_strobe", int'(strobe_dac), 0);
        chk("ar_global", int'(global_dac), 0);
        chk("ar_busy", int'(ramp_busy), 0);
        chk("ar_done", int'(ramp_done), 0);
        chk("ar_fault", int'(fault), 0);
        tick(2);
        rst_n = 1'b1; r = cyc; n6 = strobe_cyc.size();
        wait_strobes(n6 + 1, 30, "ar_restart");
        chk("ar_restart_code", strobe_code[n6], 1);
        chk("ar_restart_lat", strobe_cyc[n6] - r, 4);
        en = 1'b0;
        wait_state(1, 60, "ar_down", at);

        // target 0: no strobes; then 63 with step_div 0 (dwell of 1)
        target = 6'd0; step_div = 8'd0;
        tick(2);
        en = 1'b1; t0 = cyc; n7 = strobe_cyc.size();
        wait_state(0, 20, "z_done", at);
        chk("z_done_lat", at - t0, 3);
        chk("z_nostrobe", strobe_cyc.size(), n7);
        tick(1);
        target = 6'd63;
        wait_strobes(n7 + 63, 450, "max_strobes");
        chk("max_last_code", strobe_code[n7 + 62], 63);
        for (int i = 1; i < 63; i++) chk("max_gap", strobe_cyc[n7 + i] - strobe_cyc[n7 + i - 1], 5);
        wait_state(0, 20, "max_done", at);
        chk("max_code", int'(dac_code), 63);
        tick(10);
        chk("max_no_wrap", strobe_cyc.size(), n7 + 63);
        chk("max_done_hold", int'(ramp_done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/celera_softstart_dacseq.md
# celera_softstart_dacseq

Soft-start ramp sequencer for the 6-bit R2R ladder DAC, with output buffer, in the step-down soft-start path. On enable it wakes the DAC through `global_dac`. It then steps the DAC code one LSB at a time toward a programmable target, strobing each new code into the DAC and waiting for the DAC's `ok_dac` settle flag before the next step. On disable it ramps the code back to zero before powering the DAC down, and it flags a fault if the DAC never settles.

## Interface
Parameters:
- `TIMEOUT_W`, default 5: width of the settle-timeout counter.
- `TIMEOUT`, default 24: maximum cycles to wait for `ok_dac`, in WAKE or SETTLE, before declaring a fault.

Ports:
- `clk`, in, 1: single block clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: ramp enable, level-sensitive.
- `target`, in, 6: final DAC code. Sampled live at every step decision.
- `step_div`, in, 8: dwell cycles between steps. A value of 0 is treated as 1.
- `ok_dac`, in, 1: DAC settled/ready flag. Asynchronous to `clk`.
- `dac_code`, out, 6: drives DAC `i[5:0]`.
- `strobe_dac`, out, 1: one-cycle load pulse to the DAC.
- `global_dac`, out, 1: DAC power/enable.
- `ramp_busy`, out, 1: high in WAKE, STEP, SETTLE and HOLD.
- `ramp_done`, out, 1: high in DONE.
- `fault`, out, 1: high in FAULT.

## Operation
- `ok_dac` passes through a 2-flop synchronizer. In this document, `okq` means the synchronized value.
- Effective target `tgt_e`:
  - `tgt_e = target` while `en = 1`.
  - `tgt_e = 0` while `en = 0`.
- States:
  - **IDLE**
    - All outputs 0.
    - `en = 1` → WAKE.
  - **WAKE**
    - `global_dac = 1` and the timeout counter runs.
    - `okq = 1` → HOLD, with the dwell counter preloaded to expire immediately.
    - Counter reaches `TIMEOUT` → FAULT.
    - `en = 0` → IDLE.
  - **HOLD**
    - Dwell counter counts up to `max(step_div, 1)`.
    - On expiry, `dac_code == tgt_e` with `en = 1` → DONE.
    - On expiry, `dac_code == tgt_e` with `en = 0` (code is 0) → IDLE, and `global_dac` drops.
    - On expiry otherwise → STEP.
  - **STEP**
    - Lasts exactly one cycle.
    - `dac_code` moves one LSB toward `tgt_e` and `strobe_dac = 1`.
    - Then → SETTLE.
  - **SETTLE**
    - Blanking window of 2 cycles ignores `okq`; this covers synchronizer latency and stale highs.
    - After blanking, `okq = 1` → HOLD with the dwell counter cleared.
    - Timeout counter reaching `TIMEOUT` → FAULT.
  - **DONE**
    - `ramp_done = 1`.
    - `tgt_e != dac_code` → HOLD, preloaded to expire. This covers both a target change and `en` falling.
  - **FAULT**
    - `fault = 1`, `global_dac` stays 1 and `dac_code` is frozen. No strobes are issued.
    - `en = 0` → IDLE, with `dac_code` cleared to 0 and `global_dac = 0`.
- Code arithmetic:
  - The 6-bit code changes only by ±1 per step, so it never wraps.
  - At code 63 with target 63, no further increment occurs.
  - At code 0, no decrement occurs.
- `en` toggling mid-step never aborts SETTLE. The direction is re-evaluated at the next HOLD expiry.

## Timing
- Every output is registered. Reset values: `dac_code = 0`, `strobe_dac = 0`, `global_dac = 0`, `ramp_busy = 0`, `ramp_done = 0`, `fault = 0`.
- Enable latency: `en` rising at edge N gives `global_dac = 1` after edge N+1.
- `dac_code` updates on the same edge that raises `strobe_dac`. It is stable for at least `step_div + 3` cycles until the next strobe.
- Minimum step period with `ok_dac` already high: 1 (STEP) + 2 (blank) + 1 (settle detect) + `max(step_div, 1)` (dwell).
- The timeout counter clears on entry to WAKE and to SETTLE.
- Asserting `rst_n` low at any point forces all outputs to reset values immediately, regardless of `clk`.

## Test plan
- `ok_dac` tied high, `target = 5`, `step_div = 3`, `en` rises → `global_dac` after 1 cycle. Five strobes follow, with codes 1, 2, 3, 4, 5, spaced exactly 7 cycles apart. Then `ramp_done = 1` and `ramp_busy = 0`.
- In DONE at code 5, `target` changes to 2 → three strobes with codes 4, 3, 2, then DONE again. `target` changes to 2 → 2 again → no strobe.
- `en` falls at code 3 during SETTLE → SETTLE completes. Strobes follow with codes 2, 1, 0, then `global_dac` falls and IDLE is reached. `en` falling in WAKE → immediate IDLE with no strobe.
- `ok_dac` held low after the first strobe, `TIMEOUT = 24` → `fault = 1` after 24 SETTLE cycles and no further strobes. `dac_code` is held. `en` low → all outputs 0.
- `rst_n` pulsed low mid-ramp at code 4 → all outputs 0 without waiting for a clock edge. After release with `en = 1`, the ramp restarts from WAKE and code 0.
- `target = 0`, `en` rises, `ok_dac` high → WAKE, then DONE with zero strobes. `target = 63` → exactly 63 strobes, final code 63, with no wrap.
